// File: rtl/systolic_result_drain_if.sv
// ---------------------------------------------------------------------------
// systolic_result_drain_if
//
// Result stream between the systolic result drain and the result memory/bus.
// A word moves on every rising edge where res_val and res_rdy are both high.
//
// Build option:
//   SYSTOLIC_DRAIN_TAG_EN - when defined, res_msg carries {row, col, data}
//                           (data in the LSBs); otherwise data only.
//
// Signals:
//   res_msg  result word (NBITS, or NBITS+2*$clog2(SIZE) when tagged)
//   res_val  res_msg holds a valid word
//   res_rdy  consumer can take a word this cycle
//
// Modports:
//   master  drain side (drives res_msg/res_val, reads res_rdy)
//   slave   consumer side (reads res_msg/res_val, drives res_rdy)
// ---------------------------------------------------------------------------
interface systolic_result_drain_if #(
    parameter int SIZE  = 4,
    parameter int NBITS = 16
);
    localparam int IDX_W = $clog2(SIZE);
`ifdef SYSTOLIC_DRAIN_TAG_EN
    localparam int MSG_W = NBITS + 2 * IDX_W;
`else
    localparam int MSG_W = NBITS;
`endif

    logic [MSG_W-1:0] res_msg;
    logic             res_val;
    logic             res_rdy;

    modport master (
        output res_msg,
        output res_val,
        input  res_rdy
    );

    modport slave (
        input  res_msg,
        input  res_val,
        output res_rdy
    );
endinterface

// File: rtl/systolic_result_drain.sv
// ---------------------------------------------------------------------------
// systolic_result_drain
//
// Downstream stage of the systolic datapath. Once a matrix multiply has
// finished, start kicks off a walk over all SIZE x SIZE PE accumulators in
// row-major order through the datapath's result select (out_en/out_rsel/
// out_csel). The selected accumulator comes back combinationally on b_s_out,
// is captured into a one-deep output register and streamed out on the
// val/rdy result interface. busy stays high for the whole drain so the
// controller keeps mac_en low and the accumulators stay frozen.
//
// Build option:
//   SYSTOLIC_DRAIN_TAG_EN - when defined, each result word also carries the
//                           row/col index of the captured element as
//                           {row, col, data}. Cycle behaviour is identical.
//
// Parameters:
//   SIZE   array dimension, power of two, >= 2
//   NBITS  accumulator / result word width
//
// Ports:
//   clk       rising-edge clock
//   rst_n     asynchronous active-low reset
//   start     pulse: accumulators are valid, begin drain (ignored unless idle)
//   busy      high from the cycle after an accepted start through done
//   done      one-cycle pulse after the last result handshake
//   out_en    result select enable toward the datapath
//   out_rsel  row select toward the datapath
//   out_csel  column select toward the datapath
//   b_s_out   selected accumulator from the datapath (combinational)
//   res       result stream (master side)
// ---------------------------------------------------------------------------
module systolic_result_drain #(
    parameter int SIZE  = 4,
    parameter int NBITS = 16
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    output logic                      busy,
    output logic                      done,
    output logic                      out_en,
    output logic [$clog2(SIZE)-1:0]   out_rsel,
    output logic [$clog2(SIZE)-1:0]   out_csel,
    input  logic [NBITS-1:0]          b_s_out,
    systolic_result_drain_if.master   res
);

    localparam int IDX_W = $clog2(SIZE);
`ifdef SYSTOLIC_DRAIN_TAG_EN
    localparam int MSG_W = NBITS + 2 * IDX_W;
`else
    localparam int MSG_W = NBITS;
`endif

    localparam logic [IDX_W-1:0] IDX_ONE = IDX_W'(1);
    localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(SIZE - 1);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_DRAIN = 2'd1;
    localparam logic [1:0] ST_FLUSH = 2'd2;
    localparam logic [1:0] ST_DONE  = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [IDX_W-1:0] row_q,   row_d;
    logic [IDX_W-1:0] col_q,   col_d;
    logic [MSG_W-1:0] msg_q,   msg_d;
    logic             val_q,   val_d;
    logic             load;
    logic [MSG_W-1:0] capture;

    // Word captured from the datapath for the element currently selected.
`ifdef SYSTOLIC_DRAIN_TAG_EN
    assign capture = {row_q, col_q, b_s_out};
`else
    assign capture = b_s_out;
`endif

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        msg_d   = msg_q;
        val_d   = val_q;
        load    = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_DRAIN;
                    row_d   = '0;
                    col_d   = '0;
                end
            end

            ST_DRAIN: begin
                // The output register can take a new word when it is empty
                // or its current word leaves on this same edge.
                load = !val_q || res.res_rdy;
                if (load) begin
                    msg_d = capture;
                    val_d = 1'b1;
                    // Counters are exactly IDX_W wide, so the wrap back to
                    // zero at SIZE-1 is plain overflow.
                    col_d = col_q + IDX_ONE;
                    if (col_q == IDX_MAX) begin
                        row_d = row_q + IDX_ONE;
                        if (row_q == IDX_MAX) begin
                            state_d = ST_FLUSH;
                        end
                    end
                end
            end

            ST_FLUSH: begin
                // Last word is still in the output register; wait for it
                // to be taken before declaring the drain finished.
                if (res.res_rdy) begin
                    val_d   = 1'b0;
                    state_d = ST_DONE;
                end
            end

            ST_DONE: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            row_q   <= '0;
            col_q   <= '0;
            msg_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            msg_q   <= msg_d;
            val_q   <= val_d;
        end
    end

    // Selects are driven straight from the counters so the datapath returns
    // the addressed accumulator within the same cycle; they are parked at
    // zero outside the drain.
    always_comb begin
        busy     = (state_q != ST_IDLE);
        done     = (state_q == ST_DONE);
        out_en   = (state_q == ST_DRAIN);
        out_rsel = (state_q == ST_DRAIN) ? row_q : '0;
        out_csel = (state_q == ST_DRAIN) ? col_q : '0;
    end

    assign res.res_msg = msg_q;
    assign res.res_val = val_q;

    // A stalled word must stay put until the consumer takes it.
    a_stall_hold: assert property (
        @(posedge clk) disable iff (!rst_n)
        (res.res_val && !res.res_rdy) |=> (res.res_val && $stable(res.res_msg))
    );

    // done is a single-cycle pulse.
    a_done_pulse: assert property (
        @(posedge clk) disable iff (!rst_n)
        done |=> !done
    );

    // The accumulators are only addressed while the drain owns them.
    a_en_busy: assert property (
        @(posedge clk) disable iff (!rst_n)
        out_en |-> busy
    );

endmodule
